fetch_miinst_queue: RTL and testbench
=====================================

// Module: fetch_miinst_queue
// PURPOSE
//  Elastic FIFO of micro-instructions (miinst_t) between the x86 translate/rename front end and decode_phase.
//  Absorbs decode stalls and presents the oldest entry on deq_miinst_head; decode consumes it when not stalled.
//  Shows the NOP miinst when empty, so decode needs no separate valid qualifier.
// PARAMETERS
//  DEPTH  8  entry count; power of two, >=2. PTR_W=$clog2(DEPTH), CNT_W=PTR_W+1
// PORTS
//  clk              in   1        single clock; all state updates on posedge
//  rstn             in   1        asynchronous active-low reset
//  enq_miinst       in   miinst_t micro-instruction offered by the front end
//  enq_valid        in   1        enq_miinst is valid this cycle
//  enq_ready        out  1        queue accepts a push this cycle (= ~full)
//  deq_miinst_head  out  miinst_t oldest entry, or NOP when empty
//  deq_valid        out  1        deq_miinst_head is a real entry
//  stall            in   1        decode holds; head is not popped
//  flush            in   1        branch/exception redirect; discard all entries
//  count            out  CNT_W    current occupancy 0..DEPTH
// BEHAVIOUR
//  - Async reset (rstn=0): rd_ptr=0, wr_ptr=0, count=0, deq_valid=0, enq_ready=1, head=NOP. Entry storage is not reset.
//  - push = enq_valid & enq_ready & ~flush. pop = deq_valid & ~stall & ~flush.
//  - enq_ready depends only on count, never on stall or enq_valid. This leaves no combinational loop to the front end.
//  - Push writes storage[wr_ptr], wr_ptr+1 mod DEPTH. Pop does rd_ptr+1 mod DEPTH.
//  - count' = count + push - pop. Push and pop in the same cycle leave count unchanged.
//  - Full (count==DEPTH): enq_ready=0; a same-cycle pop does NOT re-open ready until the next cycle.
//  - Empty (count==0): deq_valid=0, head=NOP. Pop is impossible, so a stall on empty has no effect.
//  - Pointers wrap silently. count alone distinguishes full from empty.
//  - Head is combinational from storage[rd_ptr], muxed to NOP when empty. Without bypass, push-to-head latency is 1 cycle.
//  - flush is synchronous and has priority over push and pop.
//  - On flush, the next edge gives rd_ptr=wr_ptr=0 and count=0. An entry offered in the flush cycle is dropped.
//  - A flush while stalled still empties the queue.
//  - Reset asserted mid-operation discards all contents immediately. Outputs take reset values while rstn=0.
//  - NOP encoding: op=MIOP_NOP; d, s, t, imm, bmd and pc all zero.
// CONFIGURATION
//  MIQ_BYPASS_EN defined: zero-latency bypass when count==0 and enq_valid and ~flush.
//    - deq_miinst_head=enq_miinst and deq_valid=1 in the same cycle.
//    - If ~stall, the entry is consumed directly: no storage write, count stays 0.
//    - If stall, it is pushed normally.
//  MIQ_BYPASS_EN undefined: no bypass. Head path is purely from storage (1-cycle latency, shorter timing path).
// STRUCTURE
//  - The shared package (common_params) holds:
//    - miinst_t, MIOP_NOP, and a MIINST_NOP constant (replacing locally built nop structs);
//    - a typedef miq_cnt_t parameterised by DEPTH where tool support allows.
//  - Sub-module miq_ptr_ctrl: holds rd_ptr/wr_ptr/count.
//    - Inputs: push, pop, flush.
//    - Outputs: pointers, count, full, empty.
//  - Top level: storage array, head mux and bypass mux.
// TESTING
//  1 Reset, then 3 pushes (pc=1,2,3), stall=0 -> head pc=1,2,3 on consecutive cycles, then NOP with deq_valid=0.
//  2 stall=1, push DEPTH=8 entries -> count=8, enq_ready=0; 9th offer ignored.
//    Release stall -> pc order preserved, ready returns cycle after first pop.
//  3 count=4, assert flush with enq_valid=1 -> next cycle count=0, head=NOP, pushed entry absent.
//  4 count=2, simultaneous push+pop for 10 cycles -> count stays 2, FIFO order intact across pointer wrap.
//  5 rstn low for 1 cycle mid-stream (count=5), async, off clock edge -> count=0, deq_valid=0 before next posedge.
//  6 MIQ_BYPASS_EN: empty, enq pc=7, stall=0 -> head pc=7 same cycle, count stays 0.
//    Same with stall=1 -> count=1.
//    Undefined -> head pc=7 appears next cycle.

Source files
------------

// File: rtl/fetch_miinst_queue_pkg.sv
// Shared definitions for the fetch micro-instruction queue: the micro-instruction
// record, its opcode enum, the NOP constant shown on an empty queue, and the
// default occupancy-counter type.
package common_params;

    localparam int MIQ_DEPTH = 8;
    localparam int MIQ_PTR_W = $clog2(MIQ_DEPTH);
    localparam int MIQ_CNT_W = MIQ_PTR_W + 1;

    // Occupancy counter for the default depth (packages cannot take parameters).
    typedef logic [MIQ_CNT_W-1:0] miq_cnt_t;

    typedef enum logic [3:0] {
        MIOP_NOP    = 4'd0,
        MIOP_ALU    = 4'd1,
        MIOP_LOAD   = 4'd2,
        MIOP_STORE  = 4'd3,
        MIOP_BRANCH = 4'd4
    } miop_t;

    typedef struct packed {
        miop_t       op;
        logic [4:0]  d;
        logic [4:0]  s;
        logic [4:0]  t;
        logic [15:0] imm;
        logic [3:0]  bmd;
        logic [31:0] pc;
    } miinst_t;

    localparam miinst_t MIINST_NOP = '{
        op:  MIOP_NOP,
        d:   5'd0,
        s:   5'd0,
        t:   5'd0,
        imm: 16'd0,
        bmd: 4'd0,
        pc:  32'd0
    };

endpackage

// File: rtl/fetch_miinst_queue_ptr_ctrl.sv
// Read/write pointer and occupancy bookkeeping for the micro-instruction queue.
// Pointers wrap silently; count alone tells full from empty. flush wins over
// push and pop and returns everything to zero on the next edge.
module miq_ptr_ctrl
    import common_params::*;
#(
    parameter int DEPTH = MIQ_DEPTH
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH)-1:0] rd_ptr,
    output logic [$clog2(DEPTH)-1:0] wr_ptr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Next-state: flush clears, otherwise advance pointers and adjust occupancy.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // State registers with asynchronous reset to an empty queue.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_ptr = rd_ptr_q;
    assign wr_ptr = wr_ptr_q;
    assign count  = count_q;
    assign full   = (count_q == CNT_W'(DEPTH));
    assign empty  = (count_q == '0);

endmodule

// File: rtl/fetch_miinst_queue.sv
// Elastic FIFO of micro-instructions between translate/rename and decode.
// The oldest entry is presented on deq_miinst_head, or MIINST_NOP when empty.
// enq_ready depends only on occupancy, keeping the front-end path loop-free.
// Optional feature: define MIQ_BYPASS_EN for a zero-latency empty-queue bypass;
// without it, head comes purely from storage (push-to-head latency of 1 cycle).
module fetch_miinst_queue
    import common_params::*;
#(
    parameter int DEPTH = MIQ_DEPTH
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  miinst_t                enq_miinst,
    input  logic                   enq_valid,
    output logic                   enq_ready,
    output miinst_t                deq_miinst_head,
    output logic                   deq_valid,
    input  logic                   stall,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             byp_hit;

    miinst_t mem_q [DEPTH];

    miq_ptr_ctrl #(
        .DEPTH (DEPTH)
    ) u_ptr_ctrl (
        .clk    (clk),
        .rstn   (rstn),
        .push   (push),
        .pop    (pop),
        .flush  (flush),
        .rd_ptr (rd_ptr),
        .wr_ptr (wr_ptr),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    assign enq_ready = ~full;

    // Handshake decode and head selection (storage, bypass, or NOP).
    always_comb begin
        byp_hit         = 1'b0;
        push            = enq_valid & ~full & ~flush;
        pop             = ~empty & ~stall & ~flush;
        deq_valid       = ~empty;
        deq_miinst_head = empty ? MIINST_NOP : mem_q[rd_ptr];
`ifdef MIQ_BYPASS_EN
        byp_hit = empty & enq_valid & ~flush;
        if (byp_hit) begin
            deq_valid       = 1'b1;
            deq_miinst_head = enq_miinst;
            // Consumed straight from the input when decode is not holding.
            if (!stall) push = 1'b0;
        end
`endif
    end

    // Entry storage write on an accepted push.
    // NOTE: storage is deliberately not reset; count gates every read, so stale data is never visible.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr] <= enq_miinst;
    end

endmodule

// File: tb/tb_fetch_miinst_queue.sv
// Directed bench for fetch_miinst_queue: a queue-based reference model is
// compared against the DUT on every negedge, and literal expectations pin
// the model at the interesting points of each scenario.
module tb_fetch_miinst_queue;
    import common_params::*;

    localparam int DEPTH = 8;
`ifdef MIQ_BYPASS_EN
    localparam int BYP_OFS = 1;
`else
    localparam int BYP_OFS = 0;
`endif

    logic    clk;
    logic    rstn;
    miinst_t enq_miinst;
    logic    enq_valid;
    logic    enq_ready;
    miinst_t deq_miinst_head;
    logic    deq_valid;
    logic    stall;
    logic    flush;
    logic [$clog2(DEPTH):0] count;

    int vectors     = 0;
    int miscompares = 0;

    miinst_t model_q[$];

    fetch_miinst_queue #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .enq_miinst      (enq_miinst),
        .enq_valid       (enq_valid),
        .enq_ready       (enq_ready),
        .deq_miinst_head (deq_miinst_head),
        .deq_valid       (deq_valid),
        .stall           (stall),
        .flush           (flush),
        .count           (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic miinst_t mk(input int pc);
        miinst_t m;
        m.op  = MIOP_ALU;
        m.d   = pc[4:0];
        m.s   = pc[4:0] + 5'd1;
        m.t   = pc[4:0] + 5'd2;
        m.imm = pc[15:0] ^ 16'hA5A5;
        m.bmd = pc[3:0];
        m.pc  = pc;
        return m;
    endfunction

    task automatic drive(input bit v, input int pc, input bit st, input bit fl);
        enq_valid  = v;
        enq_miinst = mk(pc);
        stall      = st;
        flush      = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: one clock edge of FIFO semantics on a plain queue.
    function automatic void model_step();
        int  n;
        bit  do_pop;
        bit  do_push;
        n       = model_q.size();
        do_pop  = (n > 0) && !stall;
        do_push = enq_valid && (n < DEPTH);
`ifdef MIQ_BYPASS_EN
        if (n == 0 && enq_valid && !stall) do_push = 1'b0;
`endif
        if (flush) begin
            model_q.delete();
        end else begin
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back(enq_miinst);
        end
    endfunction

    task automatic compare_outputs();
        miinst_t eh;
        logic    ev;
        int      n;
        n  = model_q.size();
        eh = (n > 0) ? model_q[0] : MIINST_NOP;
        ev = (n > 0);
`ifdef MIQ_BYPASS_EN
        if (n == 0 && enq_valid && !flush) begin
            eh = enq_miinst;
            ev = 1'b1;
        end
`endif
        check("model_count", 128'(count), 128'(n));
        check("model_enq_ready", 128'(enq_ready), 128'(n < DEPTH));
        check("model_deq_valid", 128'(deq_valid), 128'(ev));
        check("model_head", 128'(deq_miinst_head), 128'(eh));
    endtask

    always @(posedge clk or negedge rstn) begin
        if (!rstn) model_q.delete();
        else       model_step();
    end

    always @(negedge clk) begin
        if (rstn) compare_outputs();
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b1;
        drive(0, 0, 0, 0);
        #2 rstn = 1'b0;
        #1;
        check("reset_count", 128'(count), 0);
        check("reset_enq_ready", 128'(enq_ready), 1);
        check("reset_deq_valid", 128'(deq_valid), 0);
        check("reset_head", 128'(deq_miinst_head), 128'(MIINST_NOP));
        #9 rstn = 1'b1;
        tick();

        // 1: three pushes with decode free-running
        drive(1, 1, 0, 0);
        @(negedge clk);
        check("t1_first_valid", 128'(deq_valid), 128'(BYP_OFS));
        tick();
        drive(1, 2, 0, 0);
        @(negedge clk);
        check("t1_head_a", 128'(deq_miinst_head.pc), 128'(1 + BYP_OFS));
        tick();
        drive(1, 3, 0, 0);
        @(negedge clk);
        check("t1_head_b", 128'(deq_miinst_head.pc), 128'(2 + BYP_OFS));
        tick();
        drive(0, 0, 0, 0);
        tick();
        @(negedge clk);
        check("t1_drained_valid", 128'(deq_valid), 0);
        check("t1_drained_head", 128'(deq_miinst_head), 128'(MIINST_NOP));
        tick();

        // 2: fill to DEPTH under stall, 9th offer ignored, ordered drain
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 10 + i, 1, 0);
            tick();
        end
        drive(1, 18, 1, 0);
        @(negedge clk);
        check("t2_full_count", 128'(count), 8);
        check("t2_full_ready", 128'(enq_ready), 0);
        check("t2_full_head", 128'(deq_miinst_head.pc), 10);
        tick();
        drive(1, 18, 0, 0);
        @(negedge clk);
        check("t2_pop_cycle_ready", 128'(enq_ready), 0);
        tick();
        drive(0, 0, 0, 0);
        @(negedge clk);
        check("t2_ready_back", 128'(enq_ready), 1);
        check("t2_count_7", 128'(count), 7);
        check("t2_head_11", 128'(deq_miinst_head.pc), 11);
        for (int i = 0; i < DEPTH; i++) tick();
        check("t2_empty", 128'(count), 0);

        // 3: flush at count 4 with a concurrent offer while stalled
        for (int i = 0; i < 4; i++) begin
            drive(1, 20 + i, 1, 0);
            tick();
        end
        drive(1, 24, 1, 1);
        @(negedge clk);
        check("t3_pre_flush_count", 128'(count), 4);
        tick();
        drive(0, 0, 0, 0);
        @(negedge clk);
        check("t3_flush_count", 128'(count), 0);
        check("t3_flush_valid", 128'(deq_valid), 0);
        check("t3_flush_head", 128'(deq_miinst_head), 128'(MIINST_NOP));
        tick();

        // 4: steady push+pop at count 2 across pointer wrap
        for (int i = 0; i < 2; i++) begin
            drive(1, 30 + i, 1, 0);
            tick();
        end
        for (int k = 0; k < 10; k++) begin
            drive(1, 32 + k, 0, 0);
            @(negedge clk);
            check("t4_stream_head", 128'(deq_miinst_head.pc), 128'(30 + k));
            check("t4_stream_count", 128'(count), 2);
            tick();
        end
        drive(0, 0, 0, 0);
        @(negedge clk);
        check("t4_tail_a", 128'(deq_miinst_head.pc), 40);
        tick();
        @(negedge clk);
        check("t4_tail_b", 128'(deq_miinst_head.pc), 41);
        tick();
        @(negedge clk);
        check("t4_empty", 128'(count), 0);
        tick();

        // 5: asynchronous reset mid-stream, off the clock edge
        for (int i = 0; i < 5; i++) begin
            drive(1, 50 + i, 1, 0);
            tick();
        end
        drive(0, 0, 1, 0);
        check("t5_pre_reset_count", 128'(count), 5);
        #2 rstn = 1'b0;
        #1;
        check("t5_reset_count", 128'(count), 0);
        check("t5_reset_valid", 128'(deq_valid), 0);
        check("t5_reset_ready", 128'(enq_ready), 1);
        check("t5_reset_head", 128'(deq_miinst_head), 128'(MIINST_NOP));
        #2 rstn = 1'b1;
        #1;
        check("t5_after_release_count", 128'(count), 0);
        check("t5_after_release_valid", 128'(deq_valid), 0);
        tick();
        drive(0, 0, 0, 0);
        tick();

        // 6: empty-queue latency, with and without bypass
        drive(1, 7, 0, 0);
        @(negedge clk);
`ifdef MIQ_BYPASS_EN
        check("t6_byp_head", 128'(deq_miinst_head.pc), 7);
        check("t6_byp_valid", 128'(deq_valid), 1);
        tick();
        drive(0, 0, 0, 0);
        @(negedge clk);
        check("t6_byp_count", 128'(count), 0);
        check("t6_byp_consumed", 128'(deq_valid), 0);
        tick();
        drive(1, 7, 1, 0);
        @(negedge clk);
        check("t6_byp_stall_head", 128'(deq_miinst_head.pc), 7);
        tick();
        drive(0, 0, 1, 0);
        @(negedge clk);
        check("t6_byp_stall_count", 128'(count), 1);
        tick();
`else
        check("t6_nobyp_not_yet", 128'(deq_valid), 0);
        tick();
        drive(0, 0, 0, 0);
        @(negedge clk);
        check("t6_nobyp_head", 128'(deq_miinst_head.pc), 7);
        check("t6_nobyp_valid", 128'(deq_valid), 1);
        tick();
        @(negedge clk);
        check("t6_nobyp_count", 128'(count), 0);
`endif
        drive(0, 0, 0, 0);
        tick();
        tick();
        @(negedge clk);
        check("final_empty", 128'(count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
